apb4_master: RTL and testbench

APB4_MASTER -- requirements
Module: apb4_master

---
 rtl/apb4_pkg.sv | 28 ++
 rtl/apb4_intf.sv | 34 +++
 rtl/apb4_master.sv | 155 +++++++++++++++
 tb/tb_apb4_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_pkg.sv
// -----------------------------------------------------------------------------
// apb4_pkg
// Types and constants shared by the APB4 master and its users.
//   apb4_mst_state_e : master FSM states (IDLE, SETUP, ACCESS, RESP)
//   apb4_phase_t     : {psel, penable} pair that defines the APB bus phase
//   PHASE_*          : bus-phase encodings for idle, SETUP and ACCESS
// -----------------------------------------------------------------------------
package apb4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb4_mst_state_e;

   typedef struct packed {
      logic psel;
      logic penable;
   } apb4_phase_t;

   localparam apb4_phase_t PHASE_IDLE   = '{psel: 1'b0, penable: 1'b0};
   localparam apb4_phase_t PHASE_SETUP  = '{psel: 1'b1, penable: 1'b0};
   localparam apb4_phase_t PHASE_ACCESS = '{psel: 1'b1, penable: 1'b1};

   localparam logic [2:0] PPROT_RESET = 3'b000;

endpackage : apb4_pkg

// File: rtl/apb4_intf.sv
// -----------------------------------------------------------------------------
// apb4_intf
// APB4 bus bundle.
//   master modport : drives paddr, psel, penable, pwrite, pwdata, pstrb, pprot;
//                    samples pready, prdata, pslverr
//   slave modport  : the mirror image
// -----------------------------------------------------------------------------
interface apb4_intf #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0]   paddr;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic [2:0]              pprot;
   logic                    pready;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
      output pready, prdata, pslverr
   );

endinterface : apb4_intf

// File: rtl/apb4_master.sv
// -----------------------------------------------------------------------------
// apb4_master
// Converts a valid/ready command into one APB4 transfer and returns the result
// on a valid/ready response channel. One transfer in flight at a time.
// Ports:
//   clk, rst            : clock (rising edge) and async active-high reset
//   m_apb               : APB4 master modport
//   req_valid/req_ready : command handshake (ready only while idle)
//   req_write, req_addr, req_wdata, req_strb, req_prot : command fields
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : read data (0 for writes and timeouts)
//   rsp_err             : pslverr seen or timeout
//   rsp_timeout         : transfer aborted after TIMEOUT_CYCLES wait states
// -----------------------------------------------------------------------------
module apb4_master
   import apb4_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   apb4_intf.master                m_apb,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_strb,
   input  logic [2:0]              req_prot,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   // Keep at least one bit so TIMEOUT_CYCLES=0 still elaborates.
   localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   apb4_mst_state_e         state_q;
   apb4_phase_t             phase_q;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic                    pwrite_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic [STRB_W-1:0]       pstrb_q;
   logic [2:0]              pprot_q;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic                    rsp_err_q;
   logic                    rsp_timeout_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic                    timeout_hit;

   // Wait-state count including the current non-ready ACCESS cycle.
   always_comb begin
      cnt_d       = cnt_q + CNT_W'(1);
      timeout_hit = TIMEOUT_EN && (cnt_d == CNT_LIMIT);
   end

   // Transfer sequencer; every bus and response output is a register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         phase_q       <= PHASE_IDLE;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         pprot_q       <= PPROT_RESET;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  paddr_q  <= req_addr;
                  pwrite_q <= req_write;
                  pwdata_q <= req_wdata;
                  // Reads never carry byte strobes on APB4.
                  pstrb_q  <= req_write ? req_strb : '0;
                  pprot_q  <= req_prot;
                  cnt_q    <= '0;
                  phase_q  <= PHASE_SETUP;
                  state_q  <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               phase_q <= PHASE_ACCESS;
               state_q <= ST_ACCESS;
            end

            ST_ACCESS: begin
               // pready has priority over a timeout landing in the same cycle.
               if (m_apb.pready) begin
                  phase_q       <= PHASE_IDLE;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= pwrite_q ? '0 : m_apb.prdata;
                  rsp_err_q     <= m_apb.pslverr;
                  rsp_timeout_q <= 1'b0;
                  state_q       <= ST_RESP;
               end else if (timeout_hit) begin
                  cnt_q         <= cnt_d;
                  phase_q       <= PHASE_IDLE;
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= '0;
                  rsp_err_q     <= 1'b1;
                  rsp_timeout_q <= 1'b1;
                  state_q       <= ST_RESP;
               end else if (TIMEOUT_EN) begin
                  cnt_q <= cnt_d;
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end

            default: begin
               phase_q <= PHASE_IDLE;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Command acceptance follows the state alone.
   assign req_ready = (state_q == ST_IDLE);

   assign m_apb.paddr   = paddr_q;
   assign m_apb.psel    = phase_q.psel;
   assign m_apb.penable = phase_q.penable;
   assign m_apb.pwrite  = pwrite_q;
   assign m_apb.pwdata  = pwdata_q;
   assign m_apb.pstrb   = pstrb_q;
   assign m_apb.pprot   = pprot_q;

   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule : apb4_master

// File: tb/tb_apb4_master.sv
// -----------------------------------------------------------------------------
// tb_apb4_master
// Self-checking bench for apb4_master (TIMEOUT_CYCLES=4). The expected bus
// phases and response of each transfer are derived from the number of wait
// states the bench's slave inserts.
// -----------------------------------------------------------------------------
module tb_apb4_master;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_strb;
   logic [2:0]    req_prot;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   apb4_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

   apb4_master #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .m_apb      (apb.master),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_strb   (req_strb),
      .req_prot   (req_prot),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Slave inputs outside ACCESS are randomised: the master must ignore them.
   task automatic slave_noise();
      apb.pready  = 1'($urandom);
      apb.prdata  = $urandom;
      apb.pslverr = 1'($urandom);
   endtask

   task automatic chk_addr_phase(input string tag, input logic [AW-1:0] a, input logic wr,
                                 input logic [DW-1:0] wd, input logic [SW-1:0] st,
                                 input logic [2:0] pr);
      chk({tag, "_paddr"},  apb.paddr,  a);
      chk({tag, "_pwrite"}, apb.pwrite, wr);
      chk({tag, "_pwdata"}, apb.pwdata, wd);
      chk({tag, "_pstrb"},  apb.pstrb,  st);
      chk({tag, "_pprot"},  apb.pprot,  pr);
   endtask

   // One complete transfer: slave answers after 'waits' non-ready ACCESS
   // cycles, response held off for 'bp' cycles.
   task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, input logic [2:0] pr, input int waits,
                       input logic [DW-1:0] rd, input logic serr, input int bp);
      logic [SW-1:0] exp_strb;
      bit            timed_out;
      int            n_access;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
      exp_strb  = wr ? st : '0;
      timed_out = (TO != 0) && (waits >= int'(TO));
      n_access  = timed_out ? int'(TO) : waits + 1;
      exp_rdata = (timed_out || wr) ? '0 : rd;
      exp_err   = timed_out ? 1'b1 : serr;

      @(negedge clk);
      chk("idle_req_ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      req_strb  = st;
      req_prot  = pr;
      @(posedge clk); #1;
      // Scramble the command bus: the master must use its registered copy.
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_strb  = SW'($urandom);
      req_prot  = 3'($urandom);
      chk("setup_psel", apb.psel, 1'b1);
      chk("setup_penable", apb.penable, 1'b0);
      chk("setup_req_ready", req_ready, 1'b0);
      chk("setup_rsp_valid", rsp_valid, 1'b0);
      chk_addr_phase("setup", a, wr, wd, exp_strb, pr);
      slave_noise();

      for (int k = 1; k <= n_access; k++) begin
         @(posedge clk); #1;
         chk("access_psel", apb.psel, 1'b1);
         chk("access_penable", apb.penable, 1'b1);
         chk("access_rsp_valid", rsp_valid, 1'b0);
         chk_addr_phase("access", a, wr, wd, exp_strb, pr);
         if (k == waits + 1) begin
            apb.pready  = 1'b1;
            apb.prdata  = rd;
            apb.pslverr = serr;
         end else begin
            apb.pready  = 1'b0;
            apb.prdata  = $urandom;
            apb.pslverr = 1'($urandom);
         end
      end

      @(posedge clk); #1;
      slave_noise();
      for (int b = 0; b <= bp; b++) begin
         chk("resp_valid", rsp_valid, 1'b1);
         chk("resp_rdata", rsp_rdata, exp_rdata);
         chk("resp_err", rsp_err, exp_err);
         chk("resp_timeout", rsp_timeout, timed_out);
         chk("resp_psel", apb.psel, 1'b0);
         chk("resp_penable", apb.penable, 1'b0);
         chk("resp_req_ready", req_ready, 1'b0);
         chk("resp_paddr_kept", apb.paddr, a);
         if (b < bp) begin
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            slave_noise();
         end else begin
            rsp_ready = 1'b1;
         end
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("post_req_ready", req_ready, 1'b1);
      chk("post_rsp_valid", rsp_valid, 1'b0);
   endtask

   initial begin
      rst         = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      req_strb    = '0;
      req_prot    = '0;
      rsp_ready   = 1'b0;
      apb.pready  = 1'b0;
      apb.prdata  = '0;
      apb.pslverr = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_psel", apb.psel, 1'b0);
      chk("rst_penable", apb.penable, 1'b0);
      chk_addr_phase("rst", '0, 1'b0, '0, '0, 3'd0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, '0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_rsp_timeout", rsp_timeout, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 1'b1);

      // Directed cases
      xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'd0, 0, 32'h0, 1'b0, 0);        // zero-wait write
      xfer(1'b0, 32'h8, 32'h0, 4'hF, 3'd2, 3, 32'h12345678, 1'b0, 0);        // 3 waits, pready in 4th
      xfer(1'b0, 32'h10, 32'h0, 4'h3, 3'd1, 0, 32'hCAFEF00D, 1'b1, 0);       // read slave error
      xfer(1'b1, 32'h14, 32'h55AA55AA, 4'h5, 3'd7, 1, 32'hFFFFFFFF, 1'b1, 0); // write slave error
      xfer(1'b0, 32'h20, 32'h0, 4'h0, 3'd0, 10, 32'hBAD0BAD0, 1'b0, 0);      // timeout
      xfer(1'b1, 32'h24, 32'h01020304, 4'h9, 3'd3, 2, 32'h0, 1'b0, 5);       // backpressure

      // Reset during a wait-state ACCESS
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h30;
      req_strb  = 4'hF;
      req_prot  = 3'd0;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      apb.pready = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      chk("pre_rst_penable", apb.penable, 1'b1);
      rst = 1'b1;
      #1;
      chk("midrst_psel", apb.psel, 1'b0);
      chk("midrst_penable", apb.penable, 1'b0);
      chk("midrst_rsp_valid", rsp_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_req_ready", req_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         slave_noise();
         @(posedge clk); #1;
         chk("midrst_no_rsp", rsp_valid, 1'b0);
         chk("midrst_idle_psel", apb.psel, 1'b0);
      end
      xfer(1'b1, 32'h34, 32'hA5A5A5A5, 4'hC, 3'd5, 1, 32'h0, 1'b0, 1);

      // Randomised transfers, back-to-back or with idle gaps
      for (int t = 0; t < 40; t++) begin
         logic wr;
         wr = 1'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            slave_noise();
            repeat ($urandom_range(1, 3)) @(posedge clk);
         end
         xfer(wr, $urandom, $urandom, SW'($urandom), 3'($urandom),
              int'($urandom_range(0, 6)), $urandom, ($urandom_range(0, 3) == 0),
              int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_apb4_master
